// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - LED ON/OFF phase sequencer driving a millisecond timer
module led_blink_ctrl #(
  parameter int DEF_ON_MS  = 500,
  parameter int DEF_OFF_MS = 500,
  parameter int MS_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [MS_W-1:0] on_ms,
  input  logic [MS_W-1:0] off_ms,
  input  logic            cfg_wr,
  output logic            cfg_pending,
  input  logic [MS_W-1:0] timer_ms,
  output logic            timer_en,
  output logic            timer_rst,
  output logic            led,
  output logic            phase_tick,
  output logic [MS_W-1:0] blink_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR_ON  = 3'd1;
  localparam logic [2:0] S_ON      = 3'd2;
  localparam logic [2:0] S_CLR_OFF = 3'd3;
  localparam logic [2:0] S_OFF     = 3'd4;

  localparam logic [MS_W-1:0] MS_ONE  = MS_W'(1);
  localparam logic [MS_W-1:0] DEF_ON  = MS_W'(DEF_ON_MS);
  localparam logic [MS_W-1:0] DEF_OFF = MS_W'(DEF_OFF_MS);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [MS_W-1:0] act_on;
  logic [MS_W-1:0] act_off;
  logic [MS_W-1:0] pend_on;
  logic [MS_W-1:0] pend_off;
  logic [MS_W-1:0] eff_on;
  logic [MS_W-1:0] eff_off;
  logic            on_done;
  logic            off_done;

  // A zero duration is stretched to 1 ms so a phase can never finish in its own clear cycle
  assign eff_on   = (act_on  == '0) ? MS_ONE : act_on;
  assign eff_off  = (act_off == '0) ? MS_ONE : act_off;
  assign on_done  = (state == S_ON)  && (timer_ms >= eff_on);
  assign off_done = (state == S_OFF) && (timer_ms >= eff_off);

  // A phase only ends (and is only counted) while still enabled; dropping en wins
  assign phase_tick = en && (on_done || off_done);

  // Moore outputs: the timer is held cleared outside the two counting states
  assign led       = (state == S_CLR_ON) || (state == S_ON);
  assign timer_en  = (state == S_ON) || (state == S_OFF);
  assign timer_rst = !((state == S_IDLE) || (state == S_CLR_ON) || (state == S_CLR_OFF));

  // Next-state selection; en low returns to IDLE from any state
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_CLR_ON;
        S_CLR_ON:  state_nxt = S_ON;
        S_ON:      if (on_done) state_nxt = S_CLR_OFF;
        S_CLR_OFF: state_nxt = S_OFF;
        S_OFF:     if (off_done) state_nxt = S_CLR_ON;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Double-buffered config: active values change only in CLR_ON, i.e. at a period boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_on      <= DEF_ON;
      act_off     <= DEF_OFF;
      pend_on     <= '0;
      pend_off    <= '0;
      cfg_pending <= 1'b0;
    end else if (state == S_CLR_ON) begin
      if (cfg_wr) begin
        act_on  <= on_ms;
        act_off <= off_ms;
      end else if (cfg_pending) begin
        act_on  <= pend_on;
        act_off <= pend_off;
      end
      cfg_pending <= 1'b0;
    end else if (cfg_wr) begin
      pend_on     <= on_ms;
      pend_off    <= off_ms;
      cfg_pending <= 1'b1;
    end
  end

  // Completed-period counter, advanced at the end of each OFF phase; wraps naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
    end else if (en && off_done) begin
      blink_cnt <= blink_cnt + MS_ONE;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb/tb_led_blink_ctrl.sv - randomized scoreboard bench for led_blink_ctrl
`timescale 1ns/1ps
module tb_led_blink_ctrl;

  localparam int DEF_ON  = 500;
  localparam int DEF_OFF = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_wr;
  logic [15:0] on_ms;
  logic [15:0] off_ms;
  logic [15:0] timer_ms;
  logic [15:0] blink_cnt;
  logic        cfg_pending;
  logic        timer_en;
  logic        timer_rst;
  logic        led;
  logic        phase_tick;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_blink_ctrl #(
    .DEF_ON_MS (DEF_ON),
    .DEF_OFF_MS(DEF_OFF),
    .MS_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .on_ms      (on_ms),
    .off_ms     (off_ms),
    .cfg_wr     (cfg_wr),
    .cfg_pending(cfg_pending),
    .timer_ms   (timer_ms),
    .timer_en   (timer_en),
    .timer_rst  (timer_rst),
    .led        (led),
    .phase_tick (phase_tick),
    .blink_cnt  (blink_cnt)
  );

  // Timer model: 1 ms = 10 clk; the clearing edge counts as the first prescaler tick
  int tcnt = 1;
  always @(posedge clk) begin
    if (timer_rst === 1'b0) tcnt <= 1;
    else if (timer_en === 1'b1) tcnt <= tcnt + 1;
  end
  assign timer_ms = 16'(tcnt / 10);

  typedef struct {
    logic        led;
    logic        ten;
    logic        trst;
    logic        pend;
    logic        tick;
    logic [15:0] cnt;
    int          len;
  } exp_t;

  exp_t q[$];

  // Reference model: tracks position within a phase in clock cycles; a phase of v ms
  // (0 counts as 1) occupies 10*v+1 cycles including its clear cycle
  bit          m_run = 0;
  bit          m_on  = 0;
  int          m_pos = 0;
  logic [15:0] m_cnt = '0;
  int          a_on  = DEF_ON;
  int          a_off = DEF_OFF;
  int          p_on  = 0;
  int          p_off = 0;
  bit          p_v   = 0;
  bit          force_req = 0;

  function automatic int plen(input int ms);
    return 10 * ((ms == 0) ? 1 : ms) + 1;
  endfunction

  // Model step on every edge; pushes the expected outputs for the cycle that follows
  always @(posedge clk) begin
    exp_t e;
    int   len;
    if (!rst) begin
      m_run = 0; m_on = 0; m_pos = 0; m_cnt = '0;
      a_on = DEF_ON; a_off = DEF_OFF; p_v = 0; p_on = 0; p_off = 0;
    end else begin
      if (m_run && m_on && m_pos == 0) begin
        if (cfg_wr) begin
          a_on = int'(on_ms); a_off = int'(off_ms);
        end else if (p_v) begin
          a_on = p_on; a_off = p_off;
        end
        p_v = 0;
      end else if (cfg_wr) begin
        p_on = int'(on_ms); p_off = int'(off_ms); p_v = 1;
      end
      len = plen(m_on ? a_on : a_off);
      if (!en) begin
        m_run = 0;
      end else if (!m_run) begin
        m_run = 1; m_on = 1; m_pos = 0;
      end else if (m_pos == len - 1) begin
        if (!m_on) m_cnt = m_cnt + 16'd1;
        m_on = !m_on; m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (force_req) m_cnt = 16'hFFFF;
    end
    len    = plen(m_on ? a_on : a_off);
    e.led  = m_run && m_on;
    e.ten  = m_run && (m_pos > 0);
    e.trst = m_run && (m_pos > 0);
    e.pend = p_v;
    e.tick = m_run && (m_pos == len - 1);
    e.cnt  = m_cnt;
    e.len  = len;
    q.push_back(e);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h at t=%0t", nm, act, req, $time);
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge
  logic prev_led = 1'b0;
  int   run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (led === prev_led) run++;
    else run = 1;
    prev_led = led;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("led",         {31'd0, led},         {31'd0, e.led});
      chk("timer_en",    {31'd0, timer_en},    {31'd0, e.ten});
      chk("timer_rst",   {31'd0, timer_rst},   {31'd0, e.trst});
      chk("cfg_pending", {31'd0, cfg_pending}, {31'd0, e.pend});
      chk("phase_tick",  {31'd0, phase_tick},  {31'd0, e.tick});
      chk("blink_cnt",   {16'd0, blink_cnt},   {16'd0, e.cnt});
      if (e.tick) chk("phase_len", run, e.len);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int a, input int b);
    on_ms  = 16'(a);
    off_ms = 16'(b);
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_led(input logic v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (led === v) return;
    end
    n_checks++;
    $display("FAIL wait_led: led=%b, required %b within 300 cycles", led, v);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cfg_wr = 1'b0; on_ms = '0; off_ms = '0;
    cyc(5);
    rst = 1'b1;
    cyc(100);

    cfg(3, 2);
    cyc(10);
    en = 1'b1;
    wait_led(1'b1); wait_led(1'b0); wait_led(1'b1); wait_led(1'b0); wait_led(1'b1);

    cyc(15);
    cfg(5, 5);
    wait_led(1'b0); wait_led(1'b1); wait_led(1'b0); wait_led(1'b1);

    cyc(3);
    cfg(0, 0);
    repeat (6) begin
      wait_led(1'b0); wait_led(1'b1);
    end

    cfg(2, 3);
    wait_led(1'b0); wait_led(1'b1); cyc(2); wait_led(1'b0);
    cyc($urandom_range(1, 25));
    en = 1'b0;
    cyc(8);
    en = 1'b1;
    wait_led(1'b1);

    repeat (25) begin
      cyc($urandom_range(1, 60));
      if ($urandom_range(0, 1) == 1) cfg($urandom_range(0, 4), $urandom_range(0, 4));
    end

    wait_led(1'b0); wait_led(1'b1); cyc(3);
    #1;
    force dut.blink_cnt = 16'hFFFF;
    force_req = 1'b1;
    @(posedge clk);
    #1 force_req = 1'b0;
    @(negedge clk);
    #1 release dut.blink_cnt;
    wait_led(1'b0); wait_led(1'b1); cyc(3);

    cyc(2);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(40);
    en = 1'b0;
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
